retire_trace_buffer: RTL
========================

Name: retire_trace_buffer

Overview:
- Sits directly downstream of the riscv core's observation outputs. Consumes the core's register write-back port (reg_write_sig, reg_num, reg_data) and its data-memory port (wr, rd, addr, wr_data, rd_data).
- Each cycle that has an architectural side effect is packed into one trace entry and queued in a FIFO.
- The FIFO drains over a valid/ready stream to a trace sink (testbench scoreboard or UART dumper).
- The block is passive. It never stalls the core; when full it drops entries and counts them.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of 2 and at least 2.
- ADDR_W, 9: memory address width, matches the core addr port.
- DATA_W, 32: register and memory data width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- reg_write_sig, input, 1: core register write strobe.
- reg_num, input, 5: destination register index.
- reg_data, input, DATA_W: write-back value.
- wr, input, 1: core memory write strobe.
- rd, input, 1: core memory read strobe.
- addr, input, ADDR_W: memory address.
- wr_data, input, DATA_W: store data.
- rd_data, input, DATA_W: load data.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: sink accepts the head entry.
- out_entry, output, ENTRY_W: head entry. ENTRY_W = 2*DATA_W + ADDR_W + 8, which is 81 at the defaults.
- level, output, $clog2(DEPTH)+1: current occupancy.
- ovf, output, 1: sticky overflow flag.
- drop_cnt, output, 16: count of dropped entries.
- clear_ovf, input, 1: clears ovf and drop_cnt.

Behaviour:
- Reset is asserted by reset=0, asynchronously. All of the following go to 0: pointers, level, out_valid, ovf, drop_cnt. out_entry is don't-care while out_valid=0.
- Reset mid-operation discards all queued entries.
- Capture condition, evaluated each rising edge: ev = (reg_write_sig && reg_num!=0) || wr || rd. Writes to x0 with no memory op are not traced.
- Entry layout, MSB to LSB:
  - reg_vld: reg_write_sig && reg_num!=0
  - reg_num: 5 bits
  - reg_data: DATA_W bits
  - mem_op[1:0]: 00 none, 01 read, 10 write, 11 both
  - addr: ADDR_W bits
  - mem_data: DATA_W bits
- Field-zeroing rules:
  - reg_num and reg_data are forced to 0 when reg_vld=0.
  - addr is forced to 0 when mem_op=00.
- mem_data selection: rd_data for mem_op=01, wr_data for 10 and 11, otherwise 0.
- Push occurs when ev=1 and the FIFO is not full. Full means level==DEPTH with no pop this cycle.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop when full: both succeed and level stays at DEPTH.
- Simultaneous push and pop when empty: the push is written and out_valid rises next cycle. There is no same-cycle bypass.
- Latency: an event sampled at edge N appears on out_valid/out_entry after edge N, i.e. it is visible in cycle N+1.
- Output stability: out_entry is read from the head slot. It is stable while out_valid=1 and out_ready=0.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately.
  - level counts +1 on push only, -1 on pop only, and is unchanged on both or neither.
- Drop: ev=1 while full and no pop. The entry is discarded and ovf is set to 1.
  - drop_cnt increments and saturates at 16'hFFFF.
- clear_ovf=1 at an edge clears ovf and drop_cnt to 0. If a drop happens in the same cycle, it wins: ovf=1 and drop_cnt=1.
- The block has no backpressure to the core.

Optional Feature:
- Macro: TRACE_CYCLE_STAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter is added. It resets to 0 and wraps at 2^32.
  - The counter value at the capture edge is prepended as the MSBs of each entry, so ENTRY_W = 2*DATA_W + ADDR_W + 40.
  - The counter runs regardless of FIFO state.
- When undefined: no counter exists, and the entry layout is exactly as above.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles then release, with all strobes 0 for 10 cycles -> out_valid=0, level=0, ovf=0, drop_cnt=0 throughout.
- Single register write: reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF for one cycle, out_ready=1 -> out_valid=1 for exactly one cycle, next cycle; entry has reg_vld=1, reg_num=5, reg_data=DEADBEEF, mem_op=00, addr=0, mem_data=0.
- x0 filter and combined event:
  - reg_num=0 write alone -> no entry.
  - A cycle with rd=1, addr=9'h04C, rd_data=32'h12 and reg write x7=32'h12 -> one entry with reg_vld=1, reg_num=7, mem_op=01, addr=04C, mem_data=12.
- Fill and overflow: out_ready=0, 18 consecutive wr events at DEPTH=16 -> level=16, ovf=1, drop_cnt=2. Then out_ready=1 -> 16 entries are drained in push order and level returns to 0.
- Full with simultaneous push and pop: at level=16, hold ev=1 and out_ready=1 for 5 cycles -> level stays 16, drop_cnt unchanged, order preserved.
- Clear vs. drop plus reset mid-stream:
  - clear_ovf=1 in the same cycle as a drop -> ovf=1, drop_cnt=1.
  - reset asserted with level=8 -> level=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Passive retire-trace capture. Packs every cycle that has an architectural
//   side effect (a register write to a non-zero register and/or a data-memory
//   access) into one entry and queues it in a FIFO. The FIFO drains over a
//   valid/ready stream. The core is never stalled: when the FIFO is full,
//   entries are dropped and counted.
//
//   Optional build macro: TRACE_CYCLE_STAMP_EN
//     When defined, a 32-bit free-running cycle counter is added. Its value
//     at the capture edge is prepended as the MSBs of each entry.
//
//   Entry layout, MSB to LSB:
//     [stamp(32)] reg_vld | reg_num(5) | reg_data | mem_op(2) | addr | mem_data

module retire_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int STAMP_W = 32,
`else
  localparam int STAMP_W = 0,
`endif
  localparam int ENTRY_W = 2*DATA_W + ADDR_W + 8 + STAMP_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reg_write_sig,
  input  logic [4:0]         reg_num,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               wr,
  input  logic               rd,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_entry,
  output logic [LVL_W-1:0]   level,
  output logic               ovf,
  output logic [15:0]        drop_cnt,
  input  logic               clear_ovf
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic               reg_vld;
  logic [1:0]         mem_op;
  logic               ev;
  logic [4:0]         num_f;
  logic [DATA_W-1:0]  rdata_f;
  logic [ADDR_W-1:0]  addr_f;
  logic [DATA_W-1:0]  mdata_f;
  logic [ENTRY_W-1:0] new_entry;

  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]        cycle_cnt;

  // Free-running stamp counter, independent of FIFO state; wraps at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  // Event detection and entry packing, with unused fields forced to zero so
  // that identical events always produce identical entries.
  always_comb begin
    reg_vld = reg_write_sig && (reg_num != 5'd0);
    mem_op  = {wr, rd};
    ev      = reg_vld || wr || rd;

    num_f   = reg_vld ? reg_num  : '0;
    rdata_f = reg_vld ? reg_data : '0;
    addr_f  = (mem_op != 2'b00) ? addr : '0;

    case (mem_op)
      2'b01:   mdata_f = rd_data;
      2'b10:   mdata_f = wr_data;
      2'b11:   mdata_f = wr_data;
      default: mdata_f = '0;
    endcase

`ifdef TRACE_CYCLE_STAMP_EN
    new_entry = {cycle_cnt, reg_vld, num_f, rdata_f, mem_op, addr_f, mdata_f};
`else
    new_entry = {reg_vld, num_f, rdata_f, mem_op, addr_f, mdata_f};
`endif
  end

  // Handshake decode. A pop frees a slot in the same cycle, so a push into a
  // full FIFO still succeeds when the sink is draining.
  always_comb begin
    out_valid = (level != '0);
    full      = (level == LVL_FULL);
    pop       = out_valid && out_ready;
    push      = ev && (!full || pop);
    drop      = ev && full && !pop;
  end

  // Entry storage; contents are don't-care until referenced by the pointers,
  // so the array itself is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= new_entry;
    end
  end

  assign out_entry = fifo_mem[rd_ptr];

  // Pointers wrap naturally modulo DEPTH (power of two); level tracks
  // occupancy so full and empty are never ambiguous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // Overflow bookkeeping. A drop in the same cycle as clear_ovf wins, so the
  // dropped entry is never silently lost from the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (clear_ovf) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (clear_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
